// File: rtl/seq_detect_param.sv
// seq_detect_param: run-time loadable N-bit serial pattern detector with Mealy/registered match and saturating count
module seq_detect_param #(
  parameter int N = 3,
  parameter logic [N-1:0] RESET_PAT = 3'b101,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             x,
  input  logic             x_valid,
  input  logic             overlap,
  input  logic             load,
  input  logic [N-1:0]     pattern,
  output logic             z,
  output logic             z_q,
  output logic [CNT_W-1:0] match_count
);
  localparam int FW = $clog2(N);
  logic [N-1:0] pat_q;
  logic [N-2:0] hist;
  logic [FW-1:0] fill;
  logic [N-1:0] cat;
  logic full;
  always_comb begin
    cat = {hist, x};
    full = fill == FW'(N - 1);
    z = x_valid & ~load & full & (cat == pat_q);
  end
  // fill gates z so cleared history never fakes a match (e.g. all-zero patterns)
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      pat_q <= RESET_PAT;
      hist <= '0;
      fill <= '0;
      z_q <= 1'b0;
      match_count <= '0;
    end else begin
      z_q <= z;
      if (z && match_count != '1) match_count <= match_count + 1'b1;
      if (load) begin
        pat_q <= pattern;
        hist <= '0;
        fill <= '0;
      end else if (x_valid) begin
        hist <= (z && !overlap) ? '0 : cat[N-2:0];
        fill <= (z && !overlap) ? '0 : full ? fill : fill + 1'b1;
      end
    end
  end
endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
Parametrised serial sequence detector. It is the successor to the team's fixed three-bit Mealy "101" detector. The pattern is N bits wide and loadable at run time, overlap or non-overlap matching is selected per sample, and input samples are qualified by a valid strobe. It provides a Mealy match output, a registered match output and a saturating match counter. It sits on the serial-input path of the protocol monitors.

Parameters:
N, 3, pattern length in bits; legal range 2..16.
RESET_PAT, 3'b101 (N bits), pattern value after reset.
CNT_W, 8, match counter width.

Ports:
clk  input  1  clock, rising edge.
aresetn  input  1  asynchronous, active-low reset.
x  input  1  serial data bit.
x_valid  input  1  x is a sample this cycle.
overlap  input  1  1 = overlapping matches, 0 = non-overlapping; sampled with each valid bit.
load  input  1  load pattern this cycle.
pattern  input  N  new pattern; bit N-1 is the first bit received.
z  output  1  Mealy match: combinational, same cycle as the completing bit.
z_q  output  1  z registered one cycle.
match_count  output  CNT_W  number of matches, saturating.

Behaviour:
- Reset is asynchronous, active-low (aresetn; clock clk). While aresetn=0:
  - pat_q=RESET_PAT, hist=0 (N-1 bits), fill=0, z_q=0, match_count=0.
  - z=0, because fill=0.
- State held:
  - pat_q: current pattern.
  - hist: the last N-1 accepted bits, newest in bit 0.
  - fill: count of accepted bits, 0..N-1, saturating at N-1.
- Match condition, evaluated every cycle:
  - z = x_valid & ~load & (fill==N-1) & ({hist,x}==pat_q).
  - The fill check stops reset or flushed history from producing false matches, e.g. for pattern 000.
- load=1:
  - pat_q<=pattern; hist<=0; fill<=0.
  - A sample presented in the same cycle is discarded; z=0 that cycle.
  - The new pattern takes effect from the next cycle.
- x_valid=1, load=0, z=0: hist<={hist[N-3:0],x} (for N=2, hist<=x); fill<=min(fill+1,N-1).
- x_valid=1, load=0, z=1, overlap=1: hist shifts as above; fill stays N-1, so the matching bits can seed the next match.
- x_valid=1, load=0, z=1, overlap=0: hist<=0; fill<=0. The next match needs N fresh bits.
- x_valid=0: no state change except z_q.
- z_q<=z every cycle, giving one-cycle latency.
- match_count:
  - Increments by 1 on every cycle with z=1.
  - Holds at 2^CNT_W-1 once there; does not wrap.
  - Is not cleared by load.
- A change of overlap mid-stream applies to the sample presented in that cycle only; no state depends on it.
- Reset mid-stream aborts any partial match immediately. The first possible match is the N-th valid bit after aresetn rises.
- Holding x_valid=0 between bits never breaks a partial match; only valid bits count.

Test Plan:
1. N=3, RESET_PAT=101, overlap=1, valid bits 1,0,1,0,1 -> z=1 on bits 3 and 5 only; z_q one cycle later each time; match_count=2.
2. Same stream with overlap=0 -> z=1 on bit 3 only; bits 4,5 (0,1) give no match; match_count=1.
3. load with pattern=000 and x_valid=1,x=0 in the same cycle -> that sample is ignored; then bits 0,0 -> no match; third 0 -> z=1; a fourth 0 with overlap=1 -> z=1 again.
4. Bits 1,0 then x_valid=0 for 5 cycles, then bit 1 -> z=1 on the completing bit; gaps are ignored.
5. After bits 1,0, pulse aresetn low asynchronously mid-cycle -> z_q and match_count go to 0 immediately; a following 1 -> no match.
6. CNT_W=2, overlap=1, pattern 11, feed 6 ones -> z=1 on bits 2..6 (5 matches); match_count reaches 3 and stays at 3.
